// File: rtl/openram_bist_pkg.sv
// rtl/openram_bist_pkg.sv - shared types, encodings and march element table for the OpenRAM BIST
//
// Purpose : FSM state enum, pattern_sel encodings and the March C- element table
//           used by openram_march_bist and openram_bist_pattern_gen.
// Ports   : none (package).
package openram_bist_pkg;

  // NEXT names the address/element advance. It is folded into the last op of
  // each address so an element boundary never costs a cycle; the FSM is never
  // resident in it.
  typedef enum logic [2:0] {
    IDLE,
    RD,
    WAIT,
    CMP,
    WR,
    NEXT,
    DONE
  } state_t;

  localparam logic [1:0] PAT_SOLID     = 2'd0;
  localparam logic [1:0] PAT_CHECKER   = 2'd1;
  localparam logic [1:0] PAT_STRIPE    = 2'd2;
  localparam logic [1:0] PAT_SOLID_ALT = 2'd3;

  localparam logic [2:0] LAST_ELEM = 3'd5;

  typedef struct packed {
    logic down;       // address order: 1 = D-1..0
    logic has_read;
    logic rd_inv;     // read expects ~B
    logic has_write;
    logic wr_inv;     // write stores ~B
  } elem_t;

  // March C-: E0 up(wB) E1 up(rB,w~B) E2 up(r~B,wB)
  //           E3 down(rB,w~B) E4 down(r~B,wB) E5 up(rB)
  function automatic elem_t elem_info(input logic [2:0] e);
    elem_t r;
    case (e)
      3'd0:    r = '{down: 1'b0, has_read: 1'b0, rd_inv: 1'b0, has_write: 1'b1, wr_inv: 1'b0};
      3'd1:    r = '{down: 1'b0, has_read: 1'b1, rd_inv: 1'b0, has_write: 1'b1, wr_inv: 1'b1};
      3'd2:    r = '{down: 1'b0, has_read: 1'b1, rd_inv: 1'b1, has_write: 1'b1, wr_inv: 1'b0};
      3'd3:    r = '{down: 1'b1, has_read: 1'b1, rd_inv: 1'b0, has_write: 1'b1, wr_inv: 1'b1};
      3'd4:    r = '{down: 1'b1, has_read: 1'b1, rd_inv: 1'b1, has_write: 1'b1, wr_inv: 1'b0};
      default: r = '{down: 1'b0, has_read: 1'b1, rd_inv: 1'b0, has_write: 1'b0, wr_inv: 1'b0};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/openram_march_bist_if.sv
// rtl/openram_march_bist_if.sv - SRAM macro pin bundle between the BIST engine and one OpenRAM macro
//
// Purpose : groups the 1RW port-0 and read-only port-1 pins of the macro.
// Signals : csb0/web0 (active-low), wmask0, addr0, din0, dout0 (port 0);
//           csb1 (active-low), addr1, dout1 (port 1).
// Modports: master = BIST engine (drives strobes), slave = SRAM macro (drives dout*).
interface openram_march_bist_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) ();
  logic                    csb0;
  logic                    web0;
  logic [DATA_WIDTH/8-1:0] wmask0;
  logic [ADDR_WIDTH-1:0]   addr0;
  logic [DATA_WIDTH-1:0]   din0;
  logic [DATA_WIDTH-1:0]   dout0;
  logic                    csb1;
  logic [ADDR_WIDTH-1:0]   addr1;
  logic [DATA_WIDTH-1:0]   dout1;

  modport master (
    output csb0, web0, wmask0, addr0, din0, csb1, addr1,
    input  dout0, dout1
  );

  modport slave (
    input  csb0, web0, wmask0, addr0, din0, csb1, addr1,
    output dout0, dout1
  );
endinterface

// File: rtl/openram_bist_pattern_gen.sv
// rtl/openram_bist_pattern_gen.sv - combinational background generator for the march test
//
// Purpose : maps (pattern_sel, addr, invert) to a DATA_WIDTH background word B or ~B.
// Ports   : pattern_sel in 2, addr in ADDR_WIDTH, invert in 1, data out DATA_WIDTH.
module openram_bist_pattern_gen
  import openram_bist_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]            pattern_sel,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  invert,
  output logic [DATA_WIDTH-1:0] data
);

  logic [DATA_WIDTH-1:0] bg;

  // Every background depends on the address LSB only.
  wire unused_addr = ^addr;

  always_comb begin
    bg = '0;
    case (pattern_sel)
      PAT_CHECKER: bg = addr[0] ? {(DATA_WIDTH/8){8'hAA}} : {(DATA_WIDTH/8){8'h55}};
      PAT_STRIPE:  bg = {DATA_WIDTH{addr[0]}};
      default:     bg = '0;
    endcase
    data = bg ^ {DATA_WIDTH{invert}};
  end

endmodule

// File: rtl/openram_march_bist.sv
// rtl/openram_march_bist.sv - March C- BIST engine for one OpenRAM macro
//
// Purpose : one start pulse runs E0..E5 over every address, reports pass/fail,
//           a saturating miscompare count and the first failure's details.
// Ports   : sram_clk, reset_n (async, active-low); start, abort, pattern_sel[1:0];
//           busy, done, pass, err_count[15:0], fail_addr, fail_elem[2:0],
//           fail_data, fail_expected; sram (openram_march_bist_if.master).
module openram_march_bist
  import openram_bist_pkg::*;
#(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int WMASK_WIDTH  = DATA_WIDTH / 8,
  parameter int READ_LATENCY = 1,
  parameter int HAS_RO_PORT  = 1
) (
  input  logic                    sram_clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [1:0]              pattern_sel,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [15:0]             err_count,
  output logic [ADDR_WIDTH-1:0]   fail_addr,
  output logic [2:0]              fail_elem,
  output logic [DATA_WIDTH-1:0]   fail_data,
  output logic [DATA_WIDTH-1:0]   fail_expected,
  openram_march_bist_if.master    sram
);

  localparam int WCW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [WCW-1:0] LAT_M1 = WCW'(READ_LATENCY - 1);
  localparam logic [WCW-1:0] LAT_M2 = WCW'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

  state_t                state;
  logic [2:0]            elem;
  logic [ADDR_WIDTH-1:0] addr;
  logic [WCW-1:0]        wait_cnt;
  logic [1:0]            pat_q;

  // ---------------------------------------------------------------------------
  // Successor of the current (elem, addr): where the march goes after the last
  // op of this address.
  // ---------------------------------------------------------------------------
  elem_t                 cur;
  elem_t                 nxt_info;
  logic                  last_addr;
  logic                  march_end;
  logic [2:0]            adv_elem;
  logic [ADDR_WIDTH-1:0] adv_addr;
  logic                  idle_like;
  logic                  accept;
  logic                  rd_p1;

  always_comb begin
    cur       = elem_info(elem);
    last_addr = cur.down ? (addr == '0) : (addr == ADDR_MAX);
    march_end = last_addr && (elem == LAST_ELEM);
    adv_elem  = last_addr ? elem + 3'd1 : elem;
    nxt_info  = elem_info(adv_elem);
    if (last_addr) begin
      adv_addr = nxt_info.down ? ADDR_MAX : '0;
    end else begin
      adv_addr = cur.down ? addr - ADDR_WIDTH'(1) : addr + ADDR_WIDTH'(1);
    end
    idle_like = (state == IDLE) || (state == DONE);
    accept    = idle_like && start && !abort;
    // Every read is issued for the successor target, so the port choice
    // follows adv_elem.
    rd_p1     = (HAS_RO_PORT != 0) && (adv_elem == LAST_ELEM);
  end

  // Write data for the command registered this edge: after a read it is the
  // same address with the element's write polarity; otherwise it is the
  // successor (or address 0 of E0 on start).
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  wr_inv;
  logic [1:0]            wr_sel;
  logic [DATA_WIDTH-1:0] wr_data;

  always_comb begin
    wr_sel = idle_like ? pattern_sel : pat_q;
    if ((state == RD) || (state == WAIT)) begin
      wr_addr = addr;
      wr_inv  = cur.wr_inv;
    end else if (idle_like) begin
      wr_addr = '0;
      wr_inv  = 1'b0;
    end else begin
      wr_addr = adv_addr;
      wr_inv  = nxt_info.wr_inv;
    end
  end

  openram_bist_pattern_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_wr_pat (
    .pattern_sel (wr_sel),
    .addr        (wr_addr),
    .invert      (wr_inv),
    .data        (wr_data)
  );

  // ---------------------------------------------------------------------------
  // Read tag pipeline: a read driven in cycle c is captured by the macro at the
  // edge ending c and its data is sampled READ_LATENCY edges later, when the
  // tag reaches the last stage. This lets E5 issue a read every cycle while
  // compares trail behind.
  // ---------------------------------------------------------------------------
  logic                  pipe_v    [READ_LATENCY];
  logic [ADDR_WIDTH-1:0] pipe_addr [READ_LATENCY];
  logic [2:0]            pipe_elem [READ_LATENCY];
  logic                  pipe_inv  [READ_LATENCY];
  logic                  pipe_p1   [READ_LATENCY];

  always_ff @(posedge sram_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_v[i]    <= 1'b0;
        pipe_addr[i] <= '0;
        pipe_elem[i] <= '0;
        pipe_inv[i]  <= 1'b0;
        pipe_p1[i]   <= 1'b0;
      end
    end else begin
      pipe_v[0]    <= (state == RD) && !abort;
      pipe_addr[0] <= addr;
      pipe_elem[0] <= elem;
      pipe_inv[0]  <= cur.rd_inv;
      pipe_p1[0]   <= (HAS_RO_PORT != 0) && (elem == LAST_ELEM);
      for (int i = READ_LATENCY - 1; i > 0; i--) begin
        pipe_v[i]    <= pipe_v[i-1] && !abort;
        pipe_addr[i] <= pipe_addr[i-1];
        pipe_elem[i] <= pipe_elem[i-1];
        pipe_inv[i]  <= pipe_inv[i-1];
        pipe_p1[i]   <= pipe_p1[i-1];
      end
    end
  end

  logic [DATA_WIDTH-1:0] cmp_data;
  logic [DATA_WIDTH-1:0] exp_data;
  logic                  miscmp;

  openram_bist_pattern_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_exp_pat (
    .pattern_sel (pat_q),
    .addr        (pipe_addr[READ_LATENCY-1]),
    .invert      (pipe_inv[READ_LATENCY-1]),
    .data        (exp_data)
  );

  always_comb begin
    cmp_data = pipe_p1[READ_LATENCY-1] ? sram.dout1 : sram.dout0;
    miscmp   = pipe_v[READ_LATENCY-1] && !abort && (cmp_data != exp_data);
  end

  // ---------------------------------------------------------------------------
  // Result capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge sram_clk or negedge reset_n) begin
    if (!reset_n) begin
      err_count     <= '0;
      fail_addr     <= '0;
      fail_elem     <= '0;
      fail_data     <= '0;
      fail_expected <= '0;
    end else if (accept) begin
      err_count     <= '0;
      fail_addr     <= '0;
      fail_elem     <= '0;
      fail_data     <= '0;
      fail_expected <= '0;
    end else if (miscmp) begin
      if (err_count != 16'hFFFF) begin
        err_count <= err_count + 16'd1;
      end
      if (err_count == '0) begin
        fail_addr     <= pipe_addr[READ_LATENCY-1];
        fail_elem     <= pipe_elem[READ_LATENCY-1];
        fail_data     <= cmp_data;
        fail_expected <= exp_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer: state names the command being driven in the current cycle;
  // all SRAM strobes are registered and default to inactive every edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge sram_clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      elem        <= '0;
      addr        <= '0;
      wait_cnt    <= '0;
      pat_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      sram.csb0   <= 1'b1;
      sram.web0   <= 1'b1;
      sram.wmask0 <= '0;
      sram.addr0  <= '0;
      sram.din0   <= '0;
      sram.csb1   <= 1'b1;
      sram.addr1  <= '0;
    end else begin
      sram.csb0   <= 1'b1;
      sram.web0   <= 1'b1;
      sram.wmask0 <= '0;
      sram.csb1   <= 1'b1;
      if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
        done  <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (start) begin
              state       <= WR;
              elem        <= '0;
              addr        <= '0;
              pat_q       <= pattern_sel;
              busy        <= 1'b1;
              done        <= 1'b0;
              pass        <= 1'b0;
              sram.csb0   <= 1'b0;
              sram.web0   <= 1'b0;
              sram.wmask0 <= {WMASK_WIDTH{1'b1}};
              sram.addr0  <= wr_addr;
              sram.din0   <= wr_data;
            end
          end
          RD: begin
            if (cur.has_write) begin
              if (READ_LATENCY == 1) begin
                state       <= WR;
                sram.csb0   <= 1'b0;
                sram.web0   <= 1'b0;
                sram.wmask0 <= {WMASK_WIDTH{1'b1}};
                sram.addr0  <= wr_addr;
                sram.din0   <= wr_data;
              end else begin
                state    <= WAIT;
                wait_cnt <= '0;
              end
            end else if (march_end) begin
              // Last E5 read is out; hold strobes idle until its data lands.
              state    <= CMP;
              wait_cnt <= '0;
            end else begin
              elem <= adv_elem;
              addr <= adv_addr;
              if (rd_p1) begin
                sram.csb1  <= 1'b0;
                sram.addr1 <= adv_addr;
              end else begin
                sram.csb0  <= 1'b0;
                sram.addr0 <= adv_addr;
              end
            end
          end
          WAIT: begin
            if (wait_cnt == LAT_M2) begin
              state       <= WR;
              sram.csb0   <= 1'b0;
              sram.web0   <= 1'b0;
              sram.wmask0 <= {WMASK_WIDTH{1'b1}};
              sram.addr0  <= wr_addr;
              sram.din0   <= wr_data;
            end else begin
              wait_cnt <= wait_cnt + WCW'(1);
            end
          end
          WR: begin
            elem <= adv_elem;
            addr <= adv_addr;
            if (nxt_info.has_read) begin
              state <= RD;
              if (rd_p1) begin
                sram.csb1  <= 1'b0;
                sram.addr1 <= adv_addr;
              end else begin
                sram.csb0  <= 1'b0;
                sram.addr0 <= adv_addr;
              end
            end else begin
              sram.csb0   <= 1'b0;
              sram.web0   <= 1'b0;
              sram.wmask0 <= {WMASK_WIDTH{1'b1}};
              sram.addr0  <= wr_addr;
              sram.din0   <= wr_data;
            end
          end
          CMP: begin
            // The final compare lands on this edge, so fold it into pass.
            if (wait_cnt == LAT_M1) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_count == '0) && !miscmp;
            end else begin
              wait_cnt <= wait_cnt + WCW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_openram_march_bist.sv
// tb/tb_openram_march_bist.sv - directed self-checking bench for openram_march_bist
module tb_openram_march_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic start1, abort1, start2, abort2;
  logic [1:0] pattern_sel;
  bit flt1, flt2;

  int checks = 0;
  int errors = 0;

  // DUT1: READ_LATENCY=1, HAS_RO_PORT=1
  logic busy1, done1, pass1;
  logic [15:0] err1;
  logic [3:0] faddr1;
  logic [2:0] felem1;
  logic [31:0] fdata1, fexp1;
  openram_march_bist_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) s1 ();

  openram_march_bist #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .READ_LATENCY(1), .HAS_RO_PORT(1)) dut1 (
    .sram_clk(clk), .reset_n(reset_n), .start(start1), .abort(abort1), .pattern_sel(pattern_sel),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_addr(faddr1),
    .fail_elem(felem1), .fail_data(fdata1), .fail_expected(fexp1), .sram(s1));

  // DUT2: READ_LATENCY=2, HAS_RO_PORT=0
  logic busy2, done2, pass2;
  logic [15:0] err2;
  logic [3:0] faddr2;
  logic [2:0] felem2;
  logic [31:0] fdata2, fexp2;
  openram_march_bist_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) s2 ();

  openram_march_bist #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .READ_LATENCY(2), .HAS_RO_PORT(0)) dut2 (
    .sram_clk(clk), .reset_n(reset_n), .start(start2), .abort(abort2), .pattern_sel(pattern_sel),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .fail_addr(faddr2),
    .fail_elem(felem2), .fail_data(fdata2), .fail_expected(fexp2), .sram(s2));

  // Behavioural SRAMs; optional bit-3 stuck-at-1 at address 5.
  function automatic logic [31:0] rd_fault(input logic [31:0] d, input logic [3:0] a, input bit f);
    return (f && a == 4'd5) ? (d | 32'h8) : d;
  endfunction

  logic [31:0] mem1 [16];
  logic [31:0] mem2 [16];
  logic [31:0] stage2;

  always @(posedge clk) begin
    if (!s1.csb0) begin
      if (!s1.web0) begin
        for (int b = 0; b < 4; b++)
          if (s1.wmask0[b]) mem1[s1.addr0][b*8 +: 8] <= s1.din0[b*8 +: 8];
      end else begin
        s1.dout0 <= rd_fault(mem1[s1.addr0], s1.addr0, flt1);
      end
    end
    if (!s1.csb1) s1.dout1 <= rd_fault(mem1[s1.addr1], s1.addr1, flt1);
  end

  always @(posedge clk) begin
    if (!s2.csb0) begin
      if (!s2.web0) begin
        for (int b = 0; b < 4; b++)
          if (s2.wmask0[b]) mem2[s2.addr0][b*8 +: 8] <= s2.din0[b*8 +: 8];
      end else begin
        stage2 <= rd_fault(mem2[s2.addr0], s2.addr0, flt2);
      end
    end
    s2.dout0 <= stage2;
    s2.dout1 <= '0;
  end

  int p1_lo1 = 0, p1_lo2 = 0;
  always @(posedge clk) begin
    if (!s1.csb1) p1_lo1 <= p1_lo1 + 1;
    if (!s2.csb1) p1_lo2 <= p1_lo2 + 1;
  end

  // Pulse start; returns #1 after the accepting edge (cycle 0 of the run).
  task automatic kick(input int which);
    if (which == 1) start1 = 1'b1; else start2 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; start2 = 1'b0;
  endtask

  // Advance until done, bounded; cyc = edges since the accepting edge.
  task automatic wait_done(input int which, input int from, output int cyc);
    cyc = from;
    while (!((which == 1) ? done1 : done2) && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy1); end
    checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done1); end
    checks++; if (pass1 !== 1'b0) begin errors++; $display("FAIL reset_pass: got %b expected 0", pass1); end
    checks++; if (err1 !== 16'd0) begin errors++; $display("FAIL reset_err: got %h expected 0", err1); end
    checks++; if ({faddr1, felem1, fdata1, fexp1} !== '0) begin errors++; $display("FAIL reset_fail_fields: got %h/%h/%h/%h expected 0", faddr1, felem1, fdata1, fexp1); end
    checks++; if ({s1.csb0, s1.web0, s1.csb1} !== 3'b111) begin errors++; $display("FAIL reset_strobes: got %b expected 111", {s1.csb0, s1.web0, s1.csb1}); end
    checks++; if (s1.wmask0 !== 4'h0) begin errors++; $display("FAIL reset_wmask: got %h expected 0", s1.wmask0); end
    checks++; if ({s1.addr0, s1.addr1, s1.din0} !== '0) begin errors++; $display("FAIL reset_addr_din: got %h/%h/%h expected 0", s1.addr0, s1.addr1, s1.din0); end
    checks++; if ({busy2, done2, s2.csb0} !== 3'b001) begin errors++; $display("FAIL reset_dut2: got %b expected 001", {busy2, done2, s2.csb0}); end
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fault_free;
    int cyc, p0;
    pattern_sel = 2'd0;
    p0 = p1_lo1;
    kick(1);
    checks++; if ({busy1, done1} !== 2'b10) begin errors++; $display("FAIL ff_accept: got %b expected 10", {busy1, done1}); end
    checks++; if ({s1.csb0, s1.web0, s1.addr0} !== {2'b00, 4'd0}) begin errors++; $display("FAIL ff_first_cmd: got %b/%b/%h expected 0/0/0", s1.csb0, s1.web0, s1.addr0); end
    wait_done(1, 0, cyc);
    // 160 command cycles, done on the compare edge READ_LATENCY later
    checks++; if (cyc !== 161) begin errors++; $display("FAIL ff_cycles: got %0d expected 161", cyc); end
    checks++; if ({pass1, busy1} !== 2'b10) begin errors++; $display("FAIL ff_pass_busy: got %b expected 10", {pass1, busy1}); end
    checks++; if (err1 !== 16'd0) begin errors++; $display("FAIL ff_err: got %0d expected 0", err1); end
    checks++; if ({s1.csb0, s1.csb1} !== 2'b11) begin errors++; $display("FAIL ff_strobes_idle: got %b expected 11", {s1.csb0, s1.csb1}); end
    checks++; if (p1_lo1 - p0 !== 16) begin errors++; $display("FAIL ff_port1_reads: got %0d expected 16", p1_lo1 - p0); end
  endtask

  task automatic test_stuck_fault;
    int cyc;
    flt1 = 1'b1;
    kick(1);
    wait_done(1, 0, cyc);
    checks++; if (pass1 !== 1'b0) begin errors++; $display("FAIL sf_pass: got %b expected 0", pass1); end
    checks++; if (faddr1 !== 4'd5) begin errors++; $display("FAIL sf_addr: got %0d expected 5", faddr1); end
    checks++; if (felem1 !== 3'd1) begin errors++; $display("FAIL sf_elem: got %0d expected 1", felem1); end
    checks++; if (fdata1 !== 32'h8) begin errors++; $display("FAIL sf_data: got %h expected 00000008", fdata1); end
    checks++; if (fexp1 !== 32'h0) begin errors++; $display("FAIL sf_expected: got %h expected 0", fexp1); end
    checks++; if (err1 !== 16'd3) begin errors++; $display("FAIL sf_err_count: got %0d expected 3", err1); end
    flt1 = 1'b0;
  endtask

  task automatic test_checkerboard;
    int cyc;
    logic [31:0] want;
    pattern_sel = 2'd1;
    kick(1);
    for (int n = 0; n < 16; n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      want = (n % 2 == 0) ? 32'h55555555 : 32'hAAAAAAAA;
      checks++; if ({s1.web0, s1.addr0, s1.din0} !== {1'b0, 4'(n), want}) begin errors++; $display("FAIL cb_din_e0[%0d]: got web0=%b addr=%h din=%h expected 0/%h/%h", n, s1.web0, s1.addr0, s1.din0, 4'(n), want); end
    end
    wait_done(1, 15, cyc);
    checks++; if ({pass1, err1} !== {1'b1, 16'd0}) begin errors++; $display("FAIL cb_pass: got %b/%0d expected 1/0", pass1, err1); end
  endtask

  task automatic test_row_stripe;
    int cyc;
    pattern_sel = 2'd2;
    kick(1);
    checks++; if (s1.din0 !== 32'h0) begin errors++; $display("FAIL rs_din_a0: got %h expected 0", s1.din0); end
    @(posedge clk); #1;
    checks++; if (s1.din0 !== 32'hFFFFFFFF) begin errors++; $display("FAIL rs_din_a1: got %h expected ffffffff", s1.din0); end
    wait_done(1, 1, cyc);
    checks++; if (pass1 !== 1'b1) begin errors++; $display("FAIL rs_pass: got %b expected 1", pass1); end
    pattern_sel = 2'd0;
  endtask

  task automatic test_latency2;
    int cyc, p0;
    p0 = p1_lo2;
    kick(2);
    // E1 at addr0: RD at cycle 16, WAIT at 17, WR at 18
    repeat (16) @(posedge clk); #1;
    checks++; if ({s2.csb0, s2.web0, s2.addr0} !== {2'b01, 4'd0}) begin errors++; $display("FAIL l2_rd_cmd: got %b%b/%h expected 01/0", s2.csb0, s2.web0, s2.addr0); end
    @(posedge clk); #1;
    checks++; if (s2.csb0 !== 1'b1) begin errors++; $display("FAIL l2_wait_idle: got %b expected 1", s2.csb0); end
    wait_done(2, 17, cyc);
    checks++; if (cyc !== 226) begin errors++; $display("FAIL l2_cycles: got %0d expected 226", cyc); end
    checks++; if ({pass2, err2} !== {1'b1, 16'd0}) begin errors++; $display("FAIL l2_pass: got %b/%0d expected 1/0", pass2, err2); end
    checks++; if (p1_lo2 - p0 !== 0) begin errors++; $display("FAIL l2_port1_unused: got %0d expected 0", p1_lo2 - p0); end
    flt2 = 1'b1;
    kick(2);
    wait_done(2, 0, cyc);
    checks++; if ({faddr2, felem2, err2} !== {4'd5, 3'd1, 16'd3}) begin errors++; $display("FAIL l2_fault: got addr=%0d elem=%0d err=%0d expected 5/1/3", faddr2, felem2, err2); end
    checks++; if (fdata2 !== 32'h8) begin errors++; $display("FAIL l2_fault_data: got %h expected 00000008", fdata2); end
    flt2 = 1'b0;
  endtask

  task automatic test_start_abort;
    int cyc;
    kick(1);
    repeat (20) @(posedge clk); #1;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (9) @(posedge clk); #1;
    // cycle 30: E1 read of address 7 on the original timeline
    checks++; if ({s1.csb0, s1.web0, s1.addr0, busy1} !== {2'b01, 4'd7, 1'b1}) begin errors++; $display("FAIL sa_ignored_start: got %b%b/%h busy=%b expected 01/7 busy=1", s1.csb0, s1.web0, s1.addr0, busy1); end
    repeat (19) @(posedge clk); #1;
    abort1 = 1'b1;
    @(posedge clk); #1;
    abort1 = 1'b0;
    checks++; if ({busy1, done1, s1.csb0, s1.csb1} !== 4'b0011) begin errors++; $display("FAIL sa_abort: got %b expected 0011", {busy1, done1, s1.csb0, s1.csb1}); end
    kick(1);
    wait_done(1, 0, cyc);
    checks++; if ({cyc, pass1} !== {32'd161, 1'b1}) begin errors++; $display("FAIL sa_rerun: got cyc=%0d pass=%b expected 161/1", cyc, pass1); end
  endtask

  task automatic test_async_reset;
    kick(1);
    repeat (61) @(posedge clk); #1;
    // cycle 61: E2 write of address 6
    checks++; if ({s1.csb0, s1.web0, s1.addr0} !== {2'b00, 4'd6}) begin errors++; $display("FAIL ar_mid_write: got %b%b/%h expected 00/6", s1.csb0, s1.web0, s1.addr0); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({s1.csb0, s1.web0, s1.wmask0, busy1} !== {2'b11, 4'h0, 1'b0}) begin errors++; $display("FAIL ar_async: got %b%b/%h busy=%b expected 11/0 busy=0", s1.csb0, s1.web0, s1.wmask0, busy1); end
    checks++; if ({s1.addr0, s1.din0, err1} !== '0) begin errors++; $display("FAIL ar_async_vals: got %h/%h/%h expected 0", s1.addr0, s1.din0, err1); end
    @(posedge clk); #1;
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    checks++; if ({s1.csb0, busy1, done1} !== 3'b100) begin errors++; $display("FAIL ar_after_release: got %b expected 100", {s1.csb0, busy1, done1}); end
    @(posedge clk); #1;
    checks++; if ({s1.csb0, busy1} !== 2'b10) begin errors++; $display("FAIL ar_idle: got %b expected 10", {s1.csb0, busy1}); end
  endtask

  initial begin
    reset_n = 1'b0;
    start1 = 1'b0; abort1 = 1'b0;
    start2 = 1'b0; abort2 = 1'b0;
    pattern_sel = 2'd0;
    flt1 = 1'b0; flt2 = 1'b0;
    repeat (3) @(posedge clk); #1;
    test_reset;
    test_fault_free;
    test_stuck_fault;
    test_checkerboard;
    test_row_stripe;
    test_latency2;
    test_start_abort;
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
